// File: rtl/det_pkg.sv
// Shared types and constants for the shared serial "1011" detector arbiter.
package det_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShift,
    StDrain,
    StDone
  } det_state_e;

  localparam int unsigned PAT_LEN = 4;
  localparam logic [PAT_LEN-1:0] PAT = 4'b1011;

endpackage

// File: rtl/det_rr_arb.sv
// Combinational round-robin arbiter: first valid requester after last_i, with wrap.
module det_rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int unsigned    cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand     = (int'(last_i) + off) % NREQ;
      cand_idx = IDW'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/det_share_arb.sv
// Shares one external "1011" detector among NREQ requesters; returns per-word hit counts.
// Optional per-requester hit accumulators when DET_STATS_EN is defined.
module det_share_arb
  import det_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDW   = $clog2(NREQ),
  localparam int unsigned CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  det_rstn,
  output logic                  det_bit,
  input  logic                  det_match,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [CNTW-1:0]       res_hits
`ifdef DET_STATS_EN
  ,
  input  logic [IDW-1:0]        stat_sel,
  output logic [15:0]           stat_hits
`endif
);

  localparam int unsigned IW = $clog2(WIDTH);

  det_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CNTW-1:0]  hits_q, hits_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] sel_word;
  logic             clear;

  det_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .valid_i(req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    id_d      = id_q;
    last_d    = last_q;
    hits_d    = hits_q;
    req_ready = '0;
    det_bit   = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ready is held off during reset so no requester sees a phantom accept.
        req_ready = gnt & {NREQ{rstn}};
        if (gnt_any) begin
          word_d  = sel_word;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          hits_d  = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        clear   = 1'b1;
        idx_d   = IW'(WIDTH - 1);
        state_d = StShift;
      end
      StShift: begin
        det_bit = word_q[idx_q];
        // First shift cycle still shows the cleared detector's flag.
        if (det_match && (idx_q != IW'(WIDTH - 1))) hits_d = hits_q + CNTW'(1);
        if (idx_q == '0) state_d = StDrain;
        else             idx_d   = idx_q - IW'(1);
      end
      StDrain: begin
        if (det_match) hits_d = hits_q + CNTW'(1);
        state_d = StDone;
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hits_q  <= hits_d;
    end
  end

  assign det_rstn  = rstn & ~clear;
  assign res_valid = (state_q == StDone);
  assign res_id    = id_q;
  assign res_hits  = hits_q;

`ifdef DET_STATS_EN
  logic [15:0] acc_q [NREQ];
  logic [16:0] acc_sum;

  assign acc_sum = {1'b0, acc_q[id_q]} + 17'(hits_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
    end else if (res_valid && res_ready) begin
      acc_q[id_q] <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    end
  end

  assign stat_hits = acc_q[stat_sel];
`endif

endmodule

// File: tb/tb_det_share_arb.sv
// Directed bench for det_share_arb with a behavioural "1011" detector model.
module tb_det_share_arb;
  import det_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int CNTW  = 4;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  det_rstn;
  logic                  det_bit;
  logic                  det_match = 1'b0;
  logic                  res_valid;
  logic                  res_ready = 1'b1;
  logic [IDW-1:0]        res_id;
  logic [CNTW-1:0]       res_hits;
`ifdef DET_STATS_EN
  logic [IDW-1:0]        stat_sel = '0;
  logic [15:0]           stat_hits;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clr_cnt = 0;
  logic [PAT_LEN-1:0] sr = '0;

  det_share_arb #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .det_rstn (det_rstn),
    .det_bit  (det_bit),
    .det_match(det_match),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id   (res_id),
    .res_hits (res_hits)
`ifdef DET_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_hits(stat_hits)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && !det_rstn) clr_cnt <= clr_cnt + 1;
    if (!det_rstn) begin
      sr        <= '0;
      det_match <= 1'b0;
    end else begin
      sr        <= {sr[PAT_LEN-2:0], det_bit};
      det_match <= ({sr[PAT_LEN-2:0], det_bit} == PAT);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    req_valid = '0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Present a word and wait for its accept; returns in the CLEAR cycle.
  task automatic send(input int id, input logic [WIDTH-1:0] data, output int hs, output bit ok);
    req_data[id*WIDTH +: WIDTH] = data;
    req_valid[id] = 1'b1;
    #1;
    ok = 1'b0;
    hs = 0;
    for (int t = 0; t < 60; t++) begin
      if (req_ready[id]) begin
        ok = 1'b1;
        hs = cyc;
        break;
      end
      step();
    end
    step();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_res(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int t = 0; t < 60; t++) begin
      if (res_valid) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rstn = 1'b0;
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got %0b want 0", res_valid); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    total++; if (det_rstn !== 1'b0) begin bad++; $display("FAIL rst_det_rstn got %0b want 0", det_rstn); end
    total++; if (det_bit !== 1'b0) begin bad++; $display("FAIL rst_det_bit got %0b want 0", det_bit); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rst_res_id got %0d want 0", res_id); end
    total++; if (res_hits !== 4'd0) begin bad++; $display("FAIL rst_res_hits got %0d want 0", res_hits); end
    rstn = 1'b1;
    step();
    total++; if (det_rstn !== 1'b1) begin bad++; $display("FAIL rst_release_det_rstn got %0b want 1", det_rstn); end
  endtask

  task automatic test_single();
    int hs, c;
    bit ok1, ok2;
    res_ready = 1'b1;
    send(0, 8'hBB, hs, ok1);
    wait_res(c, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL single_timeout got %0b%0b want 11", ok1, ok2); end
    total++; if (c - hs !== WIDTH + 3) begin bad++; $display("FAIL single_latency got %0d want %0d", c - hs, WIDTH + 3); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL single_id got %0d want 0", res_id); end
    total++; if (res_hits !== 4'd2) begin bad++; $display("FAIL single_hits got %0d want 2", res_hits); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_accept got %0b want 0", res_valid); end
  endtask

  task automatic test_patterns();
    logic [WIDTH-1:0] words [2] = '{8'h2D, 8'h5B};
    logic [CNTW-1:0]  exp [2]   = '{4'd1, 4'd2};
    int hs, c;
    bit ok1, ok2;
    for (int i = 0; i < 2; i++) begin
      send(1, words[i], hs, ok1);
      wait_res(c, ok2);
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL pat%0d_timeout got %0b%0b want 11", i, ok1, ok2); end
      total++; if (res_id !== 2'd1) begin bad++; $display("FAIL pat%0d_id got %0d want 1", i, res_id); end
      total++; if (res_hits !== exp[i]) begin bad++; $display("FAIL pat%0d_hits got %0d want %0d", i, res_hits, exp[i]); end
      step();
    end
  endtask

  task automatic test_isolation();
    logic [WIDTH-1:0] words [2] = '{8'h01, 8'h60};
    int hs, c, clr0;
    bit ok1, ok2;
    for (int i = 0; i < 2; i++) begin
      clr0 = clr_cnt;
      send(0, words[i], hs, ok1);
      total++; if (det_rstn !== 1'b0) begin bad++; $display("FAIL iso%0d_clear got %0b want 0", i, det_rstn); end
      for (int k = WIDTH - 1; k >= 0; k--) begin
        step();
        total++; if (det_bit !== words[i][k]) begin bad++; $display("FAIL iso%0d_bit%0d got %0b want %0b", i, k, det_bit, words[i][k]); end
        total++; if (det_rstn !== 1'b1) begin bad++; $display("FAIL iso%0d_rstn%0d got %0b want 1", i, k, det_rstn); end
      end
      wait_res(c, ok2);
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL iso%0d_timeout got %0b%0b want 11", i, ok1, ok2); end
      total++; if (res_hits !== 4'd0) begin bad++; $display("FAIL iso%0d_hits got %0d want 0", i, res_hits); end
      total++; if (clr_cnt - clr0 !== 1) begin bad++; $display("FAIL iso%0d_clr_cycles got %0d want 1", i, clr_cnt - clr0); end
      step();
    end
  endtask

  task automatic test_rr();
    int exp [5] = '{0, 1, 2, 3, 0};
    int hs, prev, c;
    bit ok;
    apply_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 8'hBB;
    req_valid = '1;
    #1;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
        if (req_ready != '0) begin ok = 1'b1; break; end
        step();
      end
      hs = cyc;
      total++; if (req_ready !== 4'(1 << exp[g])) begin bad++; $display("FAIL rr%0d_grant got %b want %b", g, req_ready, 4'(1 << exp[g])); end
      if (g > 0) begin
        total++; if (hs - prev !== WIDTH + 4) begin bad++; $display("FAIL rr%0d_spacing got %0d want %0d", g, hs - prev, WIDTH + 4); end
      end
      prev = hs;
      step();
      if (g == 4) req_valid = '0;
      wait_res(c, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr%0d_timeout got 0 want 1", g); end
      total++; if (res_id !== 2'(exp[g])) begin bad++; $display("FAIL rr%0d_id got %0d want %0d", g, res_id, exp[g]); end
      total++; if (res_hits !== 4'd2) begin bad++; $display("FAIL rr%0d_hits got %0d want 2", g, res_hits); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int hs, c;
    bit ok1, ok2;
    res_ready = 1'b0;
    send(2, 8'h5B, hs, ok1);
    wait_res(c, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL bp_timeout got %0b%0b want 11", ok1, ok2); end
    req_data[0 +: WIDTH] = 8'h2D;
    req_valid[0] = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid got %0b want 1", t, res_valid); end
      total++; if (res_id !== 2'd2 || res_hits !== 4'd2) begin bad++; $display("FAIL bp%0d_data got id%0d/%0d want id2/2", t, res_id, res_hits); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp%0d_ready got %b want 0000", t, req_ready); end
      step();
    end
    res_ready = 1'b1;
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got %0b want 0", res_valid); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release_ready got %b want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    wait_res(c, ok2);
    total++; if (!ok2 || res_id !== 2'd0 || res_hits !== 4'd1) begin bad++; $display("FAIL bp_next got ok%0b id%0d/%0d want ok1 id0/1", ok2, res_id, res_hits); end
    step();
  endtask

  task automatic test_midreset();
    int hs, c, seen;
    bit ok1, ok2;
    send(1, 8'hBB, hs, ok1);
    repeat (5) step();
    total++; if (!ok1 || det_bit !== 1'b1) begin bad++; $display("FAIL mr_bit3 got ok%0b bit%0b want ok1 bit1", ok1, det_bit); end
    rstn = 1'b0;
    step();
    total++; if (det_bit !== 1'b0 || det_rstn !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0) begin
      bad++; $display("FAIL mr_idle got bit%0b rstn%0b valid%0b ready%b want 0/0/0/0000", det_bit, det_rstn, res_valid, req_ready);
    end
    rstn = 1'b1;
    seen = 0;
    for (int t = 0; t < 16; t++) begin
      step();
      if (res_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mr_no_result got %0d want 0", seen); end
    // Pointer back at NREQ-1 means requester 0 beats requester 2.
    req_data[0 +: WIDTH] = 8'h01;
    req_data[2*WIDTH +: WIDTH] = 8'hBB;
    req_valid = 4'b0101;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mr_rr_reset got %b want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    wait_res(c, ok2);
    total++; if (!ok2 || res_id !== 2'd0) begin bad++; $display("FAIL mr_first got ok%0b id%0d want ok1 id0", ok2, res_id); end
    step();
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mr_second_ready got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    wait_res(c, ok2);
    total++; if (!ok2 || res_id !== 2'd2 || res_hits !== 4'd2) begin bad++; $display("FAIL mr_req2 got ok%0b id%0d/%0d want ok1 id2/2", ok2, res_id, res_hits); end
    step();
  endtask

`ifdef DET_STATS_EN
  task automatic test_stats();
    int hs, c;
    bit ok1, ok2;
    for (int i = 0; i < 2; i++) begin
      send(3, 8'hBB, hs, ok1);
      wait_res(c, ok2);
      step();
    end
    stat_sel = 2'd3;
    #1;
    total++; if (stat_hits !== 16'd4) begin bad++; $display("FAIL stats_req3 got %0d want 4", stat_hits); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_patterns();
    test_isolation();
    test_rr();
    test_backpressure();
    test_midreset();
`ifdef DET_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
